// File: rtl/ring_store.sv
// Storage/pointer stage of the serial ring buffer: 16-entry bit store with write/read pointers and occupancy.
// Latency: a write at edge N is readable from cycle N+1; a read accepted at edge N strobes out during cycle N+1.
// Backpressure: none. Writes while full and requests while empty are dropped. RING_STORE_OVERFLOW_EN adds sticky overflow/underrun flags.
module ring_store #(
   parameter int counter_size = 4,
   parameter int buffer_size  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      txda,
   input  logic                      txc,
   input  logic                      rxreq,
   output logic [buffer_size-1:0]    buffer,
   output logic [2*counter_size:0]   ramadrs,
   output logic                      outstrobe,
   output logic                      empty,
   output logic                      full
`ifdef RING_STORE_OVERFLOW_EN
   ,
   output logic                      overflow,
   output logic                      underrun
`endif
);

   localparam logic [counter_size:0]   full_count = (counter_size+1)'(buffer_size);
   localparam logic [counter_size:0]   cnt_one    = 1;
   localparam logic [counter_size-1:0] ptr_one    = 1;

   logic [counter_size-1:0] wptr;
   logic [counter_size-1:0] rptr;
   logic [counter_size:0]   count;
   logic                    wr_acc;
   logic                    rd_acc;

   // Accept decisions and flags come from the pre-edge occupancy only
   always_comb begin
      empty   = (count == '0);
      full    = (count == full_count);
      wr_acc  = txc && !full;
      rd_acc  = rxreq && !empty;
      ramadrs = {full, wptr, rptr};
   end

   // Write side: store the bit at wptr and advance; dropped when full
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buffer <= '0;
         wptr   <= '0;
      end else if (wr_acc) begin
         buffer[wptr] <= txda;
         wptr         <= wptr + ptr_one;
      end
   end

   // Read side: strobe the oldest entry for one cycle, then step rptr past it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstrobe <= 1'b0;
         rptr      <= '0;
      end else begin
         outstrobe <= rd_acc;
         if (outstrobe) begin
            rptr <= rptr + ptr_one;
         end
      end
   end

   // Occupancy: a read frees its slot at accept, so simultaneous accepts cancel
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + cnt_one;
            2'b01:   count <= count - cnt_one;
            default: count <= count;
         endcase
      end
   end

`ifdef RING_STORE_OVERFLOW_EN
   // Sticky error flags, cleared only by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (txc && full) begin
            overflow <= 1'b1;
         end
         if (rxreq && empty) begin
            underrun <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ring_store.sv
// Bench for ring_store: queue-based reference model checked every cycle, plus directed literal checks.
// Latency: model tracks one-cycle strobe delay after read accept.
// Backpressure: none; drops while full/empty are modelled explicitly.
module tb_ring_store;

   logic        clock;
   logic        reset;
   logic        txda;
   logic        txc;
   logic        rxreq;
   logic [15:0] buffer;
   logic [8:0]  ramadrs;
   logic        outstrobe;
   logic        empty;
   logic        full;
`ifdef RING_STORE_OVERFLOW_EN
   logic        overflow;
   logic        underrun;
`endif
   logic        rxda;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 0;

   ring_store #(.counter_size(4), .buffer_size(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .txda      (txda),
      .txc       (txc),
      .rxreq     (rxreq),
      .buffer    (buffer),
      .ramadrs   (ramadrs),
      .outstrobe (outstrobe),
      .empty     (empty),
      .full      (full)
`ifdef RING_STORE_OVERFLOW_EN
      ,
      .overflow  (overflow),
      .underrun  (underrun)
`endif
   );

   // Downstream retrieve stage view
   assign rxda = buffer[ramadrs[3:0]] && outstrobe;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of stored bits, a shadow memory, and free-running slot indices
   bit         mq[$];
   logic [15:0] m_mem;
   logic [3:0]  m_wp, m_rp;
   logic        m_strobe, m_exp, m_ovf, m_und;
   bit          m_wacc, m_racc;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_mem = '0; m_wp = '0; m_rp = '0;
         m_strobe = 1'b0; m_exp = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
      end else begin
         m_wacc = txc && (mq.size() < 16);
         m_racc = rxreq && (mq.size() > 0);
         if (txc && !m_wacc) m_ovf = 1'b1;
         if (rxreq && !m_racc) m_und = 1'b1;
         if (m_strobe) m_rp = m_rp + 4'd1;
         if (m_racc) m_exp = mq.pop_front();
         if (m_wacc) begin
            m_mem[m_wp] = txda;
            m_wp = m_wp + 4'd1;
            mq.push_back(txda);
         end
         m_strobe = m_racc;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge clock) begin
      if (run_cmp) begin
         chk("buffer",    32'(buffer),    32'(m_mem));
         chk("ramadrs",   32'(ramadrs),   32'({(mq.size() == 16), m_wp, m_rp}));
         chk("outstrobe", 32'(outstrobe), 32'(m_strobe));
         chk("empty",     32'(empty),     32'(mq.size() == 0));
         chk("full",      32'(full),      32'(mq.size() == 16));
         if (m_strobe) chk("rxda", 32'(rxda), 32'(m_exp));
`ifdef RING_STORE_OVERFLOW_EN
         chk("overflow",  32'(overflow),  32'(m_ovf));
         chk("underrun",  32'(underrun),  32'(m_und));
`endif
      end
   end

   // One clock cycle of stimulus; returns 2 time units after the edge
   task automatic cyc(input logic t, input logic d, input logic r);
      txc = t; txda = d; rxreq = r;
      @(posedge clock);
      #2;
   endtask

   logic [15:0] pat;
   logic [15:0] got;
   logic [39:0] wbits;
   logic [39:0] wgot;
   int n;

   initial begin
      txc = 0; txda = 0; rxreq = 0;
      reset = 1'b1;
      #1 reset = 1'b0;
      run_cmp = 1;
      @(posedge clock); #2;
      chk("rst_ramadrs", 32'(ramadrs), 32'h0);
      chk("rst_empty",   32'(empty), 32'h1);
      chk("rst_full",    32'(full), 32'h0);
      chk("rst_strobe",  32'(outstrobe), 32'h0);
      chk("rst_buffer",  32'(buffer), 32'h0);
      reset = 1'b1;

      // Fill with 1,0,1,1,0,0,1,0,1,1,1,0,0,1,0,1
      pat = 16'hA74D;
      for (int i = 0; i < 16; i++) cyc(1'b1, pat[i], 1'b0);
      chk("fill_full",    32'(full), 32'h1);
      chk("fill_ramadrs", 32'(ramadrs), 32'h100);
      chk("fill_buffer",  32'(buffer), 32'hA74D);

      // 17th write dropped
      cyc(1'b1, 1'b0, 1'b0);
      chk("ovf_buffer",  32'(buffer), 32'hA74D);
      chk("ovf_ramadrs", 32'(ramadrs), 32'h100);
`ifdef RING_STORE_OVERFLOW_EN
      chk("ovf_flag",    32'(overflow), 32'h1);
`endif

      // Write+read at full: write dropped, read accepted
      got = '0; n = 0;
      cyc(1'b1, 1'b0, 1'b1);
      chk("sfull_strobe",  32'(outstrobe), 32'h1);
      chk("sfull_ramadrs", 32'(ramadrs), 32'h000);
      chk("sfull_buffer",  32'(buffer), 32'hA74D);
      got[n] = rxda; n++;
      for (int i = 1; i < 16; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         if (outstrobe && n < 16) begin got[n] = rxda; n++; end
      end
      chk("drain_count",   32'(n), 32'd16);
      chk("drain_data",    32'(got), 32'hA74D);
      chk("drain_ramadrs", 32'(ramadrs), 32'h00F);
      chk("drain_empty",   32'(empty), 32'h1);

      // Requests while empty
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         chk("und_strobe",  32'(outstrobe), 32'h0);
         chk("und_ramadrs", 32'(ramadrs), 32'h000);
      end
`ifdef RING_STORE_OVERFLOW_EN
      chk("und_flag", 32'(underrun), 32'h1);
`endif

      // Write+read at empty: write accepted, read ignored
      cyc(1'b1, 1'b1, 1'b1);
      chk("sempty_empty",   32'(empty), 32'h0);
      chk("sempty_strobe",  32'(outstrobe), 32'h0);
      chk("sempty_ramadrs", 32'(ramadrs), 32'h010);
      cyc(1'b0, 1'b0, 1'b1);
      chk("sempty_rd_strobe", 32'(outstrobe), 32'h1);
      chk("sempty_rd_data",   32'(rxda), 32'h1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("sempty_end_ramadrs", 32'(ramadrs), 32'h011);
      chk("sempty_end_empty",   32'(empty), 32'h1);

      // Streaming with one cycle of write lead: 40 bits through both pointers wrapping
      wbits = 40'hC95A3E71B6;
      wgot = '0; n = 0;
      for (int k = 0; k < 40; k++) begin
         cyc(1'b1, wbits[k], k > 0);
         chk("wrap_notfull", 32'(full), 32'h0);
         if (outstrobe && n < 40) begin wgot[n] = rxda; n++; end
      end
      cyc(1'b0, 1'b0, 1'b1);
      if (outstrobe && n < 40) begin wgot[n] = rxda; n++; end
      cyc(1'b0, 1'b0, 1'b0);
      chk("wrap_count",   32'(n), 32'd40);
      chk("wrap_lo",      wgot[31:0], wbits[31:0]);
      chk("wrap_hi",      32'(wgot[39:32]), 32'(wbits[39:32]));
      chk("wrap_ramadrs", 32'(ramadrs), 32'h099);
      chk("wrap_empty",   32'(empty), 32'h1);

      // Reset in the middle of a burst
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("mrst_ramadrs", 32'(ramadrs), 32'h0);
      chk("mrst_strobe",  32'(outstrobe), 32'h0);
      chk("mrst_buffer",  32'(buffer), 32'h0);
      chk("mrst_empty",   32'(empty), 32'h1);
      @(posedge clock); #2;
      reset = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      chk("post_buffer",  32'(buffer), 32'h0001);
      chk("post_ramadrs", 32'(ramadrs), 32'h010);
      cyc(1'b0, 1'b0, 1'b1);
      chk("post_rd_data", 32'(rxda), 32'h1);
      cyc(1'b0, 1'b0, 1'b0);

      run_cmp = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_store.md
# ring_store

Upstream storage and pointer stage of the serial ring buffer. Accepts serial bits on a write strobe, holds them in a `buffer_size`-entry register file and keeps write pointer, read pointer and occupancy. Presents the parallel `buffer`, the packed pointer bus `ramadrs` and the `outstrobe` read qualifier to the downstream retrieve stage. That stage forms `rxda = buffer[ramadrs[counter_size-1:0]] && outstrobe` combinationally.

## Interface
- `counter_size`, 4, pointer width in bits.
- `buffer_size`, 16, entry count; must equal 2**`counter_size`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `txda`  in  1  serial write data.
- `txc`  in  1  write strobe; one bit per cycle when high.
- `rxreq`  in  1  read request; one bit per cycle when high.
- `buffer`  out  `buffer_size`  storage contents, bit i = entry i.
- `ramadrs`  out  2*`counter_size`+1  [cs-1:0] read pointer, [2cs-1:cs] write pointer, [2cs] full flag.
- `outstrobe`  out  1  read data valid this cycle at `buffer[rptr]`.
- `empty`  out  1  occupancy == 0.
- `full`  out  1  occupancy == `buffer_size`.

## Operation
- State: `wptr`, `rptr` (`counter_size` bits each); `count` (`counter_size`+1 bits, 0..`buffer_size`); `buffer`; `outstrobe` register.
- Write accept: `txc && count != buffer_size`, using the pre-edge count.
  - `buffer[wptr] <= txda`.
  - `wptr <= wptr+1`; wraps modulo `buffer_size`, 15→0.
  - `count` increments.
- Write while full is dropped. `buffer`, `wptr` and `count` stay unchanged, even if a read is accepted in the same cycle.
- Read accept: `rxreq && count != 0`, using the pre-edge count.
  - `count` decrements.
  - `outstrobe <= 1`.
- Otherwise `outstrobe <= 0`. A request while empty is ignored, even if a write is accepted in the same cycle.
- Pointer advance: at every edge where `outstrobe == 1`, `rptr <= rptr+1` (wraps). The entry is therefore stable at `rptr` throughout the strobe cycle.
- Simultaneous read and write accept: `count` is unchanged and both actions occur.
- Slot reuse: count is decremented at accept, so a write may target the slot being strobed out in the same cycle. The write lands at the closing edge, after the downstream combinational read. This is legal by construction.
- Flags are combinational from `count`: `empty = (count==0)`, `full = (count==buffer_size)`, `ramadrs[2cs] = full`.
- Arithmetic: pointers use modulo-2**`counter_size` wrap and need no comparison logic. `count` never exceeds `buffer_size` and never goes below 0.
- Reset (asynchronous, any time including mid-burst) forces:
  - `wptr`, `rptr`, `count` = 0.
  - `buffer` = all zeros.
  - `outstrobe` = 0.
- Resulting outputs: `ramadrs` = 0, `empty` = 1, `full` = 0.
- After reset deassertion the block is immediately operational at the next rising edge.

## Timing
- Write latency: bit sampled at edge N is readable (`count` ≥ 1) from cycle N+1.
- Read latency: `rxreq` high before edge N gives `outstrobe` high during cycle N+1, with `rptr` at the oldest entry. `rptr` advances at edge N+1.
- Back-to-back reads: continuous `rxreq` gives continuous `outstrobe`, with `rptr` stepping by one per cycle until count reaches 0. `outstrobe` drops one cycle after the last accept.
- Throughput: one write and one read per cycle sustained.
- All outputs are registered or decoded from registers only; there are no input-to-output combinational paths.

## Configuration
- `RING_STORE_OVERFLOW_EN`:
  - Defined: adds two outputs, both cleared by `reset` only.
    - `overflow` (1 bit): sticky, set at the edge where a write is dropped while full.
    - `underrun` (1 bit): sticky, set at the edge where `rxreq` is ignored while empty.
  - Undefined: both ports and their logic are absent. Dropped writes and ignored requests remain silent; all other behaviour is identical.

## Test plan
- Reset with stimulus active: drop `reset` mid-burst while `txc` and `rxreq` are high → same cycle `ramadrs`=0, `outstrobe`=0, `buffer`=0, `empty`=1; first write after release lands at entry 0.
- Fill and drain: write pattern 1,0,1,1,... for 16 cycles, then hold `rxreq` 16 cycles:
  - `full`=1 and `ramadrs[8]`=1 after the 16th write.
  - `outstrobe` high for 16 consecutive cycles, with `rptr` stepping 0..15 and `buffer[rptr]` reproducing the pattern.
  - `empty`=1 at the end.
- Overflow: 17 writes with no reads → the 17th bit is not stored, `wptr`=0, `count`=16; with `RING_STORE_OVERFLOW_EN`, `overflow`=1 from the next cycle.
- Underrun: `rxreq` high for 3 cycles while empty → `outstrobe` stays 0, `rptr` stays 0; with the macro, `underrun`=1.
- Simultaneous at bounds:
  - At `count`=16, `txc` and `rxreq` in the same cycle → write dropped, `count`=15, `outstrobe` pulse.
  - At `count`=0, `txc` and `rxreq` in the same cycle → write accepted, read ignored, `count`=1.
- Wrap-around: stream 40 bits with `txc` and `rxreq` both continuously high (one cycle of write lead) → `count` holds 1 or 0, both pointers wrap 15→0 twice, and the output sequence equals the input delayed by 2 cycles.
